alb_core: RTL and testbench



---
 rtl/alb_pkg.sv | 11 +
 rtl/alb_comb.sv | 55 +++++
 rtl/alb_core.sv | 76 +++++++
 tb/tb_alb_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alb_pkg.sv
// rtl/alb_pkg.sv - opcode and width constants for the 4-bit arithmetic/logic block
package alb_pkg;

    localparam int ALB_W = 4;

    localparam logic [1:0] ALB_OR   = 2'b00;
    localparam logic [1:0] ALB_ADD  = 2'b01;
    localparam logic [1:0] ALB_ANDN = 2'b10;
    localparam logic [1:0] ALB_SUB  = 2'b11;

endpackage

// File: rtl/alb_comb.sv
// rtl/alb_comb.sv - combinational op and flag logic of the arithmetic/logic block
module alb_comb
    import alb_pkg::*;
(
    input  logic [ALB_W-1:0] R,
    input  logic [ALB_W-1:0] S,
    input  logic             CI,
    input  logic [1:0]       I,
    output logic [ALB_W-1:0] F,
    output logic             CO,
    output logic             VO,
    output logic             NO,
    output logic             ZO
);

    logic [ALB_W:0]   w_sum;
    logic [ALB_W-1:0] w_f;
    logic             w_co;
    logic             w_vo;

    always_comb begin
        w_sum = '0;
        w_f   = '0;
        w_co  = 1'b0;
        w_vo  = 1'b0;
        case (I)
            ALB_OR: begin
                w_f = R | S;
            end
            ALB_ADD: begin
                w_sum = {1'b0, R} + {1'b0, S} + {{ALB_W{1'b0}}, CI};
                w_f   = w_sum[ALB_W-1:0];
                w_co  = w_sum[ALB_W];
                w_vo  = (R[ALB_W-1] == S[ALB_W-1]) && (w_f[ALB_W-1] != R[ALB_W-1]);
            end
            ALB_ANDN: begin
                w_f = ~R & S;
            end
            default: begin
                // R + ~S + CI: CI=1 is a true subtract, carry-out means no borrow
                w_sum = {1'b0, R} + {1'b0, ~S} + {{ALB_W{1'b0}}, CI};
                w_f   = w_sum[ALB_W-1:0];
                w_co  = w_sum[ALB_W];
                w_vo  = (R[ALB_W-1] != S[ALB_W-1]) && (w_f[ALB_W-1] != R[ALB_W-1]);
            end
        endcase
    end

    assign F  = w_f;
    assign CO = w_co;
    assign VO = w_vo;
    assign NO = w_f[ALB_W-1];
    assign ZO = (w_f == '0);

endmodule

// File: rtl/alb_core.sv
// rtl/alb_core.sv - arithmetic/logic block top; ALB_OUTPUT_REG_EN selects registered (else combinational) outputs
module alb_core
    import alb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ALB_W-1:0] R_in,
    input  logic [ALB_W-1:0] S_in,
    input  logic             CI,
    input  logic [1:0]       I,
    output logic [ALB_W-1:0] F_ALB,
    output logic             CO,
    output logic             VO,
    output logic             NO,
    output logic             ZO
);

    logic [ALB_W-1:0] w_f;
    logic             w_co;
    logic             w_vo;
    logic             w_no;
    logic             w_zo;

    alb_comb u_comb (
        .R  (R_in),
        .S  (S_in),
        .CI (CI),
        .I  (I),
        .F  (w_f),
        .CO (w_co),
        .VO (w_vo),
        .NO (w_no),
        .ZO (w_zo)
    );

`ifdef ALB_OUTPUT_REG_EN
    logic [ALB_W-1:0] r_f;
    logic             r_co;
    logic             r_vo;
    logic             r_no;
    logic             r_zo;

    // ZO is forced low in reset rather than derived from the cleared result
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_f  <= '0;
            r_co <= 1'b0;
            r_vo <= 1'b0;
            r_no <= 1'b0;
            r_zo <= 1'b0;
        end else begin
            r_f  <= w_f;
            r_co <= w_co;
            r_vo <= w_vo;
            r_no <= w_no;
            r_zo <= w_zo;
        end
    end

    assign F_ALB = r_f;
    assign CO    = r_co;
    assign VO    = r_vo;
    assign NO    = r_no;
    assign ZO    = r_zo;
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, reset};

    assign F_ALB = w_f;
    assign CO    = w_co;
    assign VO    = w_vo;
    assign NO    = w_no;
    assign ZO    = w_zo;
`endif

endmodule

// File: tb/tb_alb_core.sv
// tb/tb_alb_core.sv - self-checking bench for alb_core against an integer-arithmetic reference model
module tb_alb_core;
    import alb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] R_in;
    logic [3:0] S_in;
    logic       CI;
    logic [1:0] I;
    logic [3:0] F_ALB;
    logic       CO;
    logic       VO;
    logic       NO;
    logic       ZO;

    int checks = 0;
    int failures = 0;

`ifdef ALB_OUTPUT_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    always #5 clk = ~clk;

    alb_core dut (
        .clk   (clk),
        .reset (reset),
        .R_in  (R_in),
        .S_in  (S_in),
        .CI    (CI),
        .I     (I),
        .F_ALB (F_ALB),
        .CO    (CO),
        .VO    (VO),
        .NO    (NO),
        .ZO    (ZO)
    );

    logic [7:0] got;
    assign got = {F_ALB, CO, VO, NO, ZO};

    // Reference: unsigned sum decides carry, signed sum out of [-8,7] decides overflow
    function automatic logic [7:0] model(input logic [3:0] r, input logic [3:0] s,
                                         input logic ci, input logic [1:0] op);
        int ur, us, sr, ss, u, sv;
        logic [3:0] f;
        logic co, vo;
        ur = int'(r);
        us = int'(s);
        sr = (ur >= 8) ? ur - 16 : ur;
        ss = (us >= 8) ? us - 16 : us;
        co = 1'b0;
        vo = 1'b0;
        case (op)
            2'd0: f = r | s;
            2'd1: begin
                u  = ur + us + int'(ci);
                sv = sr + ss + int'(ci);
                f  = 4'(u % 16);
                co = (u >= 16);
                vo = (sv > 7) || (sv < -8);
            end
            2'd2: f = (~r) & s;
            default: begin
                u  = ur + (15 - us) + int'(ci);
                sv = sr - ss - 1 + int'(ci);
                f  = 4'(u % 16);
                co = (u >= 16);
                vo = (sv > 7) || (sv < -8);
            end
        endcase
        return {f, co, vo, f[3], (f == 4'd0)};
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] s,
                         input logic ci, input logic [1:0] op);
        R_in = r;
        S_in = s;
        CI   = ci;
        I    = op;
    endtask

    task automatic settle();
        if (REG) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        reset = 1'b0;
        drive(4'h7, 4'h7, 1'b1, ALB_ADD);
        @(posedge clk);
        #1;
        exp = REG ? 8'h00 : model(4'h7, 4'h7, 1'b1, ALB_ADD);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_state got=%b expected=%b", got, exp);
        end
        reset = 1'b1;
    endtask

    task automatic test_plan_vectors();
        logic [3:0] vr [0:6] = '{4'hA, 4'h6, 4'hC, 4'h9, 4'h1, 4'h1, 4'h7};
        logic [3:0] vs [0:6] = '{4'h5, 4'h3, 4'hA, 4'h3, 4'h1, 4'h1, 4'h7};
        logic       vc [0:6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] vi [0:6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
        logic [7:0] ve [0:6] = '{8'hF2, 8'hA6, 8'h20, 8'h6C, 8'hF2, 8'h09, 8'hF6};
        for (int k = 0; k < 7; k++) begin
            drive(vr[k], vs[k], vc[k], vi[k]);
            settle();
            checks++;
            if (got !== ve[k]) begin
                failures++;
                $display("FAIL plan_vec%0d got=%b expected=%b", k, got, ve[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r, s;
        logic ci;
        logic [1:0] op;
        logic [7:0] exp;
        for (int k = 0; k < 200; k++) begin
            r  = 4'($urandom_range(0, 15));
            s  = 4'($urandom_range(0, 15));
            ci = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            drive(r, s, ci, op);
            settle();
            exp = model(r, s, ci, op);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random r=%h s=%h ci=%b op=%0d got=%b expected=%b",
                         r, s, ci, op, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back_latency();
        logic [7:0] exp_a, exp_b;
        exp_a = model(4'h7, 4'h7, 1'b1, ALB_ADD);
        exp_b = model(4'h1, 4'h1, 1'b1, ALB_SUB);
        drive(4'h7, 4'h7, 1'b1, ALB_ADD);
        settle();
        checks++;
        if (got !== exp_a) begin
            failures++;
            $display("FAIL latency_first got=%b expected=%b", got, exp_a);
        end
        drive(4'h1, 4'h1, 1'b1, ALB_SUB);
        #1;
        checks++;
        if (got !== (REG ? exp_a : exp_b)) begin
            failures++;
            $display("FAIL latency_hold got=%b expected=%b", got, REG ? exp_a : exp_b);
        end
        if (REG) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (got !== exp_b) begin
            failures++;
            $display("FAIL latency_update got=%b expected=%b", got, exp_b);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] exp;
        exp = model(4'h7, 4'h7, 1'b1, ALB_ADD);
        drive(4'h7, 4'h7, 1'b1, ALB_ADD);
        settle();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_before got=%b expected=%b", got, exp);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (got !== (REG ? 8'h00 : exp)) begin
            failures++;
            $display("FAIL mid_reset got=%b expected=%b", got, REG ? 8'h00 : exp);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (got !== (REG ? 8'h00 : exp)) begin
            failures++;
            $display("FAIL mid_release_hold got=%b expected=%b", got, REG ? 8'h00 : exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_first_valid got=%b expected=%b", got, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(4'h0, 4'h0, 1'b0, ALB_OR);
        test_reset();
        test_plan_vectors();
        test_random();
        test_back_to_back_latency();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
